serial_tx_sched: RTL and testbench

SERIAL_TX_SCHED -- requirements
Module: serial_tx_sched

---
 rtl/serial_tx_sched_pkg.sv | 24 ++
 rtl/serial_tx_sched_baud.sv | 38 +++
 rtl/serial_tx_sched.sv | 154 +++++++++++++++
 tb/tb_serial_tx_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// serial_tx_sched_pkg
// Shared definitions for the serial transmit scheduler:
//   - scheduler FSM state encoding
//   - serial start/stop bit levels
//   - frame length computation (start + data + optional parity + stop)
// ---------------------------------------------------------------------------
package serial_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Total serial bits in one frame.
  function automatic int frame_bits(input int data_bits, input int parity_en);
    return data_bits + 2 + parity_en;
  endfunction

endpackage

// File: rtl/serial_tx_sched_baud.sv
// ---------------------------------------------------------------------------
// tx_baud_cnt
// Baud-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps;
// tick is high during the last count of each bit period.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   enable     : count this cycle
//   clear      : force count back to 0 (dominates enable)
//   tick       : end of the current bit period
// ---------------------------------------------------------------------------
module tx_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/serial_tx_sched.sv
// ---------------------------------------------------------------------------
// serial_tx_sched
// Round-robin scheduler for two frame requesters feeding an external
// parallel-to-serial shifter. A granted payload is framed (start, data LSB
// first, optional even parity, stop), presented with a one-cycle load strobe,
// then shifted out with one shift strobe every CLKS_PER_BIT cycles.
// Ports:
//   clk, n_rst            : clock, asynchronous active-low reset
//   req_valid[1:0]        : per-requester frame request
//   req_data0, req_data1  : requester payloads
//   req_ready[1:0]        : per-requester accept (only in IDLE, one-hot)
//   sr_load               : load strobe to the shifter (LOAD state)
//   sr_shift              : shift strobe to the shifter
//   sr_frame              : frame for the shifter, held between loads
//   busy                  : scheduler not in IDLE
//   grant_id              : requester owning the current frame
//   tx_done               : pulse on the final shift of a frame
// ---------------------------------------------------------------------------
module serial_tx_sched
  import serial_tx_sched_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  localparam int FRAME_BITS  = frame_bits(DATA_BITS, PARITY_EN)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [1:0]            req_valid,
  input  logic [DATA_BITS-1:0]  req_data0,
  input  logic [DATA_BITS-1:0]  req_data1,
  output logic [1:0]            req_ready,
  output logic                  sr_load,
  output logic                  sr_shift,
  output logic [FRAME_BITS-1:0] sr_frame,
  output logic                  busy,
  output logic                  grant_id,
  output logic                  tx_done
);

  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  tx_state_e        state;
  tx_state_e        state_nxt;
  logic             last_grant;
  logic             winner;
  logic             handshake;
  logic             tick;
  logic             last_shift;
  logic [BIT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] data_sel;

  // Assemble the serial frame: start at bit 0, stop at the MSB.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '1;
    f[0] = START_BIT;
    f[DATA_BITS:1] = d;
    if (PARITY_EN != 0) f[DATA_BITS+1] = ^d;
    f[FRAME_BITS-1] = STOP_BIT;
    return f;
  endfunction

  // Round-robin: a tie goes to the requester not served last.
  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b11) begin
      winner = ~last_grant;
    end else if (req_valid[1]) begin
      winner = 1'b1;
    end
  end

  assign handshake  = (state == IDLE) && req_valid[winner];
  assign data_sel   = winner ? req_data1 : req_data0;
  assign last_shift = tick && (bit_cnt == LAST_BIT);

  tx_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .n_rst  (n_rst),
    .enable (state == SHIFT),
    .clear  (state != SHIFT),
    .tick   (tick)
  );

  // ---- state register ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    req_ready = 2'b00;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    tx_done   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req_valid[winner]) req_ready[winner] = 1'b1;
      end
      LOAD:  sr_load = 1'b1;
      SHIFT: begin
        sr_shift = tick;
        tx_done  = last_shift;
      end
      default: busy = 1'b1;
    endcase
  end

  // Bit position within the frame; restarts whenever a frame is not shifting.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt <= '0;
    end else if (state != SHIFT) begin
      bit_cnt <= '0;
    end else if (tick) begin
      bit_cnt <= last_shift ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  // Frame and ownership are captured at the handshake and held until the next one.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      sr_frame   <= '1;
    end else if (handshake) begin
      last_grant <= winner;
      grant_id   <= winner;
      sr_frame   <= build_frame(data_sel);
    end
  end

endmodule

// File: tb/tb_serial_tx_sched.sv
module tb_serial_tx_sched;

  localparam int C  = 4;    // main instance clocks per bit
  localparam int F  = 10;   // main instance frame bits
  localparam int PC = 2;    // parity instance clocks per bit
  localparam int PF = 11;   // parity instance frame bits

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = 2'b00;
  logic [7:0]  req_data0 = 8'h00;
  logic [7:0]  req_data1 = 8'h00;
  logic [1:0]  req_ready;
  logic        sr_load, sr_shift, busy, grant_id, tx_done;
  logic [9:0]  sr_frame;

  logic [1:0]  p_valid = 2'b00;
  logic [7:0]  p_d0 = 8'h00;
  logic [7:0]  p_d1 = 8'h00;
  logic [1:0]  p_ready;
  logic        p_load, p_shift, p_busy, p_gid, p_done;
  logic [10:0] p_frame;

  serial_tx_sched #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_data0(req_data0),
    .req_data1(req_data1), .req_ready(req_ready), .sr_load(sr_load),
    .sr_shift(sr_shift), .sr_frame(sr_frame), .busy(busy),
    .grant_id(grant_id), .tx_done(tx_done));

  serial_tx_sched #(.DATA_BITS(8), .CLKS_PER_BIT(PC), .PARITY_EN(1)) dut_par (
    .clk(clk), .n_rst(n_rst), .req_valid(p_valid), .req_data0(p_d0),
    .req_data1(p_d1), .req_ready(p_ready), .sr_load(p_load),
    .sr_shift(p_shift), .sr_frame(p_frame), .busy(p_busy),
    .grant_id(p_gid), .tx_done(p_done));

  int total = 0;
  int bad = 0;

  // Reference model: a frame is a timeline measured from its handshake cycle.
  bit         m_active;
  int         m_hs;
  int         m_cyc = 0;
  bit         m_last;
  bit         m_gid;
  logic [9:0] m_frame;

  int         grants[$];
  int         dones = 0;
  int         shifts = 0;
  logic [9:0] load_frame = '0;

  typedef struct { logic [1:0] v; logic [1:0] exp_ready; } arb_vec_t;
  typedef struct { logic [7:0] data; logic [10:0] exp_frame; } par_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = 1'b1;
    m_gid    = 1'b0;
    m_frame  = '1;
  endtask

  // One clock cycle: drive inputs, check every output against the model.
  task automatic step(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    int off;
    bit act;
    int w;
    logic [1:0] e_ready;
    bit e_load, e_shift, e_done;
    @(negedge clk);
    req_valid = v;
    req_data0 = d0;
    req_data1 = d1;
    #1;
    act = m_active;
    off = m_cyc - m_hs;
    if (act && off >= 2 + F * C) begin
      act = 1'b0;
      m_active = 1'b0;
    end
    e_ready = 2'b00;
    w = -1;
    if (!act) begin
      if (v == 2'b11)      w = m_last ? 0 : 1;
      else if (v == 2'b01) w = 0;
      else if (v == 2'b10) w = 1;
      if (w >= 0) e_ready = (w == 1) ? 2'b10 : 2'b01;
    end
    e_load  = act && (off == 1);
    e_shift = act && (off >= 2) && ((off - 2) % C == C - 1);
    e_done  = e_shift && ((off - 2) / C == F - 1);
    chk("req_ready", req_ready, e_ready);
    chk("sr_load", sr_load, e_load);
    chk("sr_shift", sr_shift, e_shift);
    chk("tx_done", tx_done, e_done);
    chk("busy", busy, act);
    chk("grant_id", grant_id, m_gid);
    chk("sr_frame", sr_frame, m_frame);
    chk("load_shift_overlap", sr_load & sr_shift, 0);
    if ((req_ready & v) != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
    if (tx_done) dones++;
    if (sr_shift) shifts++;
    if (sr_load) load_frame = sr_frame;
    if (w >= 0) begin
      m_active = 1'b1;
      m_hs     = m_cyc;
      m_last   = (w == 1);
      m_gid    = (w == 1);
      m_frame  = {1'b1, (w == 1) ? d1 : d0, 1'b0};
    end
    m_cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle, released at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    req_valid = 2'b00;
    p_valid   = 2'b00;
    n_rst     = 1'b0;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_load", sr_load, 0);
    chk("rst_shift", sr_shift, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_frame", sr_frame, 10'h3FF);
    chk("rst_p_busy", p_busy, 0);
    chk("rst_p_frame", p_frame, 11'h7FF);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    arb_vec_t arb_tbl[4];
    par_vec_t par_tbl[4];
    logic [1:0] pend;
    int gsz;
    int n;
    int d_before;

    arb_tbl[0] = '{2'b01, 2'b01};
    arb_tbl[1] = '{2'b10, 2'b10};
    arb_tbl[2] = '{2'b11, 2'b01};
    arb_tbl[3] = '{2'b00, 2'b00};

    par_tbl[0] = '{8'h07, 11'b1_1_00000111_0};
    par_tbl[1] = '{8'hA5, 11'b1_0_10100101_0};
    par_tbl[2] = '{8'h80, 11'b1_1_10000000_0};
    par_tbl[3] = '{8'h00, 11'b1_0_00000000_0};

    model_reset();
    do_reset();

    // Combinational arbitration from the reset state; valid drops before the edge.
    foreach (arb_tbl[i]) begin
      @(posedge clk);
      #1;
      req_valid = arb_tbl[i].v;
      #1;
      chk("arb_table", req_ready, arb_tbl[i].exp_ready);
      req_valid = 2'b00;
    end

    // Single frame from requester 0.
    shifts = 0;
    d_before = dones;
    step(2'b01, 8'hA5, 8'h00);
    for (int i = 0; i < 2 + F * C + 2; i++) step(2'b00, 8'h00, 8'h00);
    chk("a5_load_frame", load_frame, 10'b1_10100101_0);
    chk("a5_shift_count", shifts, F);
    chk("a5_done_count", dones - d_before, 1);

    // Both valid from reset: 0 first, then 1 at the next IDLE.
    do_reset();
    grants.delete();
    pend = 2'b11;
    n = 0;
    while ((pend != 2'b00 || busy) && n < 300) begin
      gsz = grants.size();
      step(pend, 8'h11, 8'h22);
      if (grants.size() != gsz) pend[grants[gsz]] = 1'b0;
      n++;
    end
    chk("tie_timeout", n < 300, 1);
    chk("tie_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("tie_first", grants[0], 0);
      chk("tie_second", grants[1], 1);
    end

    // Requester 1 held, requester 0 re-requests once per frame: must alternate.
    do_reset();
    grants.delete();
    pend = 2'b01;
    n = 0;
    while (grants.size() < 4 && n < 400) begin
      gsz = grants.size();
      step({1'b1, pend[0]}, 8'($urandom), 8'($urandom));
      if (grants.size() != gsz && grants[gsz] == 0) pend[0] = 1'b0;
      if (sr_load) pend[0] = 1'b1;
      n++;
    end
    chk("alt_timeout", grants.size() >= 4, 1);
    if (grants.size() >= 4) begin
      chk("alt_g0", grants[0], 0);
      chk("alt_g1", grants[1], 1);
      chk("alt_g2", grants[2], 0);
      chk("alt_g3", grants[3], 1);
    end

    // Reset during the 5th bit abandons the frame; the next request works.
    do_reset();
    step(2'b10, 8'h00, 8'h5A);
    for (int i = 0; i < 19; i++) step(2'b00, 8'h00, 8'h00);
    d_before = dones;
    do_reset();
    chk("midrst_no_done", dones, d_before);
    step(2'b01, 8'h3C, 8'h00);
    for (int i = 0; i < 2 + F * C + 2; i++) step(2'b00, 8'h00, 8'h00);
    chk("midrst_next_frame", load_frame, 10'b1_00111100_0);
    chk("midrst_next_done", dones - d_before, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] v;
      v[0] = ($urandom_range(0, 9) < 3);
      v[1] = ($urandom_range(0, 9) < 3);
      step(v, 8'($urandom), 8'($urandom));
    end

    // Parity instance: frame contents and frame length.
    req_valid = 2'b00;
    foreach (par_tbl[i]) begin
      @(negedge clk);
      p_valid = 2'b01;
      p_d0 = par_tbl[i].data;
      #1;
      chk("p_ready", p_ready, 2'b01);
      @(negedge clk);
      p_valid = 2'b00;
      #1;
      chk("p_load", p_load, 1);
      chk("p_frame", p_frame, par_tbl[i].exp_frame);
      n = 0;
      while (!p_done && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("p_done_seen", p_done, 1);
      chk("p_frame_len", n, PF * PC);
      @(negedge clk);
      #1;
      chk("p_idle", p_busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
